// File: rtl/fetch_seq.sv
// Instruction fetch/sequencer driving register-file and ALU controls; two cycles per instruction
// (FETCH presents pc, EXEC decodes imem_data combinationally). No backpressure; start is ignored while busy.
module fetch_seq #(
    parameter int PCW = 10,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [8:0]     imem_data,
    input  logic           acc_zero,
    output logic [PCW-1:0] imem_addr,
    output logic           ImmVal,
    output logic           AccWrite,
    output logic           RegWrite,
    output logic [4:0]     addr,
    output logic [2:0]     alu_op,
    output logic           busy,
    output logic           done,
    output logic           illegal,
    output logic [CW-1:0]  retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] ALU_PASS_B   = 3'd0;
    localparam logic [2:0] ALU_PASS_ACC = 3'd1;
    localparam logic [2:0] ALU_ADD      = 3'd2;
    localparam logic [2:0] ALU_SUB      = 3'd3;
    localparam logic [2:0] ALU_AND      = 3'd4;
    localparam logic [2:0] ALU_XOR      = 3'd5;

    logic [1:0]     state;
    logic [PCW-1:0] pc;
    logic [3:0]     opcode;
    logic [4:0]     operand;
    logic [PCW-1:0] br_off;
    logic           taken;
    logic           halt;
    logic           undef;

    assign opcode  = imem_data[8:5];
    assign operand = imem_data[4:0];
    // Sign-extend (or truncate, for narrow pc) the 5-bit offset; pc math wraps modulo 2**PCW.
    assign br_off  = PCW'($signed(operand));

    assign imem_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_EXEC);
    assign done      = (state == S_DONE);

    // Decode is purely combinational off state, so async reset drops every enable at once.
    always_comb begin
        ImmVal   = 1'b0;
        AccWrite = 1'b0;
        RegWrite = 1'b0;
        addr     = 5'd0;
        alu_op   = ALU_PASS_B;
        taken    = 1'b0;
        halt     = 1'b0;
        undef    = 1'b0;
        if (state == S_EXEC) begin
            addr = operand;
            case (opcode)
                4'h1: begin ImmVal = 1'b1; AccWrite = 1'b1; end
                4'h2: AccWrite = 1'b1;
                4'h3: begin RegWrite = 1'b1; alu_op = ALU_PASS_ACC; end
                4'h4: begin AccWrite = 1'b1; alu_op = ALU_ADD; end
                4'h5: begin AccWrite = 1'b1; alu_op = ALU_SUB; end
                4'h6: begin AccWrite = 1'b1; alu_op = ALU_AND; end
                4'h7: begin AccWrite = 1'b1; alu_op = ALU_XOR; end
                4'h8: begin ImmVal = 1'b1; AccWrite = 1'b1; alu_op = ALU_ADD; end
                4'h9, 4'hA, 4'hB: undef = 1'b1;
                4'hC: taken = acc_zero;
                4'hD: taken = !acc_zero;
                4'hE: taken = 1'b1;
                4'hF: halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        pc      <= '0;
                        retired <= '0;
                        illegal <= 1'b0;
                    end
                end
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    if (retired != '1)
                        retired <= retired + CW'(1);
                    if (undef)
                        illegal <= 1'b1;
                    if (halt) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                        pc    <= taken ? (pc + br_off) : (pc + PCW'(1));
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: a program-level interpreter predicts each EXEC cycle's controls.
module tb_fetch_seq;
    localparam int PCW   = 4;
    localparam int CW    = 4;
    localparam int DEPTH = 16;
    localparam int SAT   = 15;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [8:0]     imem_data;
    logic           acc_zero;
    logic [PCW-1:0] imem_addr;
    logic           ImmVal, AccWrite, RegWrite;
    logic [4:0]     addr;
    logic [2:0]     alu_op;
    logic           busy, done, illegal;
    logic [CW-1:0]  retired;

    fetch_seq #(.PCW(PCW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_data(imem_data), .acc_zero(acc_zero),
        .imem_addr(imem_addr), .ImmVal(ImmVal), .AccWrite(AccWrite), .RegWrite(RegWrite),
        .addr(addr), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [DEPTH];
    bit         az  [DEPTH];

    always @(posedge clk) imem_data <= mem[imem_addr];
    assign acc_zero = az[imem_addr];

    typedef struct {
        int pc;
        bit imm;
        bit accw;
        bit regw;
        int addr;
        int alu;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   exec_cnt = 0;
    bit   phase = 1'b0;
    bit   mon_en = 1'b0;
    rec_t mr;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic logic [8:0] ins(input int op, input int opd);
        return {op[3:0], opd[4:0]};
    endfunction

    function automatic int min_sat(input int n);
        return (n > SAT) ? SAT : n;
    endfunction

    // Interpret the program from pc 0 for at most maxi instructions.
    function automatic void model(input int maxi, output bit halted, output int n,
                                  output bit ill, output int fpc);
        int pc, op, opd, off;
        bit taken;
        rec_t r;
        pc = 0; n = 0; ill = 0; halted = 0;
        while (n < maxi && !halted) begin
            op  = int'(mem[pc][8:5]);
            opd = int'(mem[pc][4:0]);
            r.pc = pc; r.addr = opd; r.imm = 0; r.accw = 0; r.regw = 0; r.alu = 0;
            case (op)
                1: begin r.imm = 1; r.accw = 1; end
                2: r.accw = 1;
                3: begin r.regw = 1; r.alu = 1; end
                4, 5, 6, 7: begin r.accw = 1; r.alu = op - 2; end
                8: begin r.imm = 1; r.accw = 1; r.alu = 2; end
                9, 10, 11: ill = 1;
                default: ;
            endcase
            exp_q.push_back(r);
            n++;
            off   = (opd >= 16) ? opd - 32 : opd;
            taken = (op == 14) || (op == 12 && az[pc]) || (op == 13 && !az[pc]);
            if (op == 15) halted = 1;
            else if (taken) pc = ((pc + off) % DEPTH + DEPTH) % DEPTH;
            else pc = (pc + 1) % DEPTH;
        end
        fpc = pc;
    endfunction

    // Busy cycles alternate FETCH, EXEC starting with FETCH.
    always @(negedge clk) begin
        if (!mon_en || !rst_n || !busy) begin
            phase = 1'b0;
        end else if (!phase) begin
            phase = 1'b1;
            if (exp_q.size() == 0) check("fetch_unexpected", 1, 0);
            else begin
                check("fetch_addr", int'(imem_addr), exp_q[0].pc);
                check("fetch_enables", int'({ImmVal, AccWrite, RegWrite}), 0);
            end
        end else begin
            phase = 1'b0;
            if (exp_q.size() == 0) check("exec_unexpected", 1, 0);
            else begin
                mr = exp_q.pop_front();
                check("exec_pc", int'(imem_addr), mr.pc);
                check("exec_ctrl", int'({ImmVal, AccWrite, RegWrite, addr, alu_op}),
                      int'({mr.imm, mr.accw, mr.regw, mr.addr[4:0], mr.alu[2:0]}));
            end
            exec_cnt++;
        end
    end

    task automatic check_zero(input string tag);
        check(tag, int'({imem_addr, ImmVal, AccWrite, RegWrite, addr, alu_op,
                         busy, done, illegal, retired}), 0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        #1 check_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = ins(0, 0);
            az[i]  = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run(input int maxi, input bit extra_start);
        bit halted, ill;
        int n, fpc, budget;
        model(maxi, halted, n, ill, fpc);
        exec_cnt = 0;
        mon_en   = 1'b1;
        pulse_start();
        check("start_clears_illegal", int'(illegal), 0);
        check("start_clears_retired", int'(retired), 0);
        check("start_busy", int'(busy), 1);
        if (extra_start) pulse_start();
        for (budget = 0; budget < 400; budget++) begin
            if (halted ? (done == 1'b1) : (exec_cnt >= n)) break;
            @(posedge clk); #1;
        end
        mon_en = halted;
        check("run_timeout", int'(budget < 400), 1);
        check("retired", int'(retired), min_sat(n));
        check("illegal", int'(illegal), int'(ill));
        check("queue_drained", exp_q.size(), 0);
        if (halted && budget < 400) begin
            check("done_state", int'({busy, done}), 1);
            check("halt_pc", int'(imem_addr), fpc);
        end else begin
            check("still_busy", int'(busy), int'(!halted));
            do_reset();
        end
    endtask

    initial begin
        int budget;
        bit ill, halted;
        int n, fpc;
        rst_n = 1'b0;
        start = 1'b0;
        clear_prog();
        #12 check_zero("reset_outputs");
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check_zero("idle_outputs");

        // LDI 5; STR 3; HALT
        mem[0] = ins(1, 5); mem[1] = ins(3, 3); mem[2] = ins(15, 0);
        run(10, 1'b0);

        // BNZ -2 at pc 4: loops while acc nonzero, falls through to HALT otherwise
        clear_prog();
        mem[4] = ins(13, 5'b11110); mem[5] = ins(15, 0);
        run(10, 1'b1);
        az[4] = 1'b1;
        run(10, 1'b0);

        // JMP -1 at pc 0 wraps to 15; JMP +1 at pc 15 wraps to 0
        clear_prog();
        mem[0] = ins(14, 5'b11111); mem[15] = ins(14, 1);
        run(6, 1'b0);

        // Undefined opcode then HALT; illegal sticks in DONE, next start clears it
        clear_prog();
        mem[0] = ins(10, 7); mem[1] = ins(15, 0);
        run(10, 1'b0);
        run(10, 1'b1);

        // 20 NOPs wrap through pc 15 and saturate retired
        clear_prog();
        run(20, 1'b0);

        // Reset during the EXEC of a STR
        clear_prog();
        mem[0] = ins(1, 1); mem[1] = ins(3, 3); mem[2] = ins(15, 0);
        model(10, halted, n, ill, fpc);
        exec_cnt = 0;
        mon_en   = 1'b1;
        pulse_start();
        for (budget = 0; budget < 50; budget++) begin
            @(negedge clk); #1;
            if (exec_cnt >= 2) break;
        end
        check("str_exec_reached", int'(budget < 50), 1);
        check("str_regwrite_high", int'(RegWrite), 1);
        do_reset();
        check("reset_mid_run_idle", int'({busy, done}), 0);
        run(10, 1'b1);

        // Random programs, random acc_zero per pc, random start-while-busy pulses
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = 9'($urandom_range(0, 511));
                az[i]  = 1'($urandom_range(0, 1));
            end
            run($urandom_range(3, 30), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
